// File: rtl/warships_pkg.sv
// Shared cell and shot-result encodings plus board address widths for the
// warships board controller and its memory interface.
package warships_pkg;

   localparam int X_ADDR_W   = 4;
   localparam int Y_ADDR_W   = 4;
   localparam int MEM_ADDR_W = X_ADDR_W + Y_ADDR_W;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      SHIP  = 2'b01,
      MISS  = 2'b10,
      HIT   = 2'b11
   } cell_t;

   typedef enum logic [1:0] {
      RES_MISS    = 2'b00,
      RES_HIT     = 2'b01,
      RES_REPEAT  = 2'b10,
      RES_INVALID = 2'b11
   } shot_res_t;

endpackage

// File: rtl/board_sweep_cnt.sv
// Nested x/y counter for the board sweep: y runs fastest, x is the outer index.
// Exposes the successor coordinate so the caller can register it as an address.
module board_sweep_cnt #(
   parameter int X_SIZE       = 12,
   parameter int Y_SIZE       = 12,
   parameter int X_ADDR_WIDTH = 4,
   parameter int Y_ADDR_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    step,
   output logic [X_ADDR_WIDTH-1:0] next_x,
   output logic [Y_ADDR_WIDTH-1:0] next_y,
   output logic                    done
);

   localparam logic [X_ADDR_WIDTH-1:0] X_LAST = X_ADDR_WIDTH'(X_SIZE - 1);
   localparam logic [Y_ADDR_WIDTH-1:0] Y_LAST = Y_ADDR_WIDTH'(Y_SIZE - 1);

   logic [X_ADDR_WIDTH-1:0] x_q;
   logic [Y_ADDR_WIDTH-1:0] y_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else if (start) begin
         x_q <= '0;
         y_q <= '0;
      end else if (step) begin
         x_q <= next_x;
         y_q <= next_y;
      end
   end

   always_comb begin
      next_x = x_q;
      next_y = y_q + 1'b1;
      if (y_q == Y_LAST) begin
         next_x = x_q + 1'b1;
         next_y = '0;
      end
   end

   assign done = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/board_shot_ctl.sv
// Shot-resolution controller owning both board_mem ports: read-classify-write
// per shot, ship-cell counting with all_sunk, and a full-board clear sweep.
module board_shot_ctl
   import warships_pkg::*;
#(
   parameter int X_SIZE       = 12,
   parameter int Y_SIZE       = 12,
   parameter int X_ADDR_WIDTH = X_ADDR_W,
   parameter int Y_ADDR_WIDTH = Y_ADDR_W,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 shot_valid,
   output logic                                 shot_ready,
   input  logic [X_ADDR_WIDTH-1:0]              shot_x,
   input  logic [Y_ADDR_WIDTH-1:0]              shot_y,
   output logic                                 result_valid,
   output logic [1:0]                           result,
   input  logic                                 clear_req,
   output logic                                 busy,
   input  logic                                 ships_load,
   input  logic [CNT_WIDTH-1:0]                 ships_count,
   output logic                                 all_sunk,
   output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_read_addr,
   input  logic [1:0]                           mem_read_data,
   output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_write_addr,
   output logic [1:0]                           mem_write_data,
   output logic                                 mem_write_enable
);

   localparam int AW = X_ADDR_WIDTH + Y_ADDR_WIDTH;
   localparam logic [X_ADDR_WIDTH:0] X_LIM = (X_ADDR_WIDTH + 1)'(X_SIZE);
   localparam logic [Y_ADDR_WIDTH:0] Y_LIM = (Y_ADDR_WIDTH + 1)'(Y_SIZE);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      EVAL,
      RESP,
      CLEAR
   } state_t;

   state_t                  state_q, state_nxt;
   shot_res_t               result_q, eval_res;
   cell_t                   wdata_q, eval_data;
   logic                    eval_we;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_nxt;
   logic                    armed_q, armed_nxt;
   logic [X_ADDR_WIDTH-1:0] tgt_x, sw_next_x;
   logic [Y_ADDR_WIDTH-1:0] tgt_y, sw_next_y;
   logic                    sweep_start, sweep_step, sweep_done;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         IDLE: begin
            if (clear_req)       state_nxt = CLEAR;
            else if (shot_valid) state_nxt = READ;
         end
         READ:  state_nxt = EVAL;
         EVAL:  state_nxt = RESP;
         RESP:  state_nxt = IDLE;
         CLEAR: if (sweep_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      shot_ready = (state_q == IDLE) && !clear_req;
      busy       = (state_q != IDLE);
   end

   // The latched target lives in mem_read_addr; it also becomes the write address.
   assign tgt_x = mem_read_addr[AW-1:Y_ADDR_WIDTH];
   assign tgt_y = mem_read_addr[Y_ADDR_WIDTH-1:0];

   always_comb begin
      eval_res  = RES_REPEAT;
      eval_we   = 1'b0;
      eval_data = EMPTY;
      if (({1'b0, tgt_x} >= X_LIM) || ({1'b0, tgt_y} >= Y_LIM)) begin
         eval_res = RES_INVALID;
      end else begin
         case (cell_t'(mem_read_data))
            EMPTY: begin
               eval_res  = RES_MISS;
               eval_we   = 1'b1;
               eval_data = MISS;
            end
            SHIP: begin
               eval_res  = RES_HIT;
               eval_we   = 1'b1;
               eval_data = HIT;
            end
            default: eval_res = RES_REPEAT;
         endcase
      end
   end

   assign sweep_start = (state_q == IDLE) && clear_req;
   assign sweep_step  = (state_q == CLEAR) && !sweep_done;

   board_sweep_cnt #(
      .X_SIZE      (X_SIZE),
      .Y_SIZE      (Y_SIZE),
      .X_ADDR_WIDTH(X_ADDR_WIDTH),
      .Y_ADDR_WIDTH(Y_ADDR_WIDTH)
   ) u_sweep (
      .clk   (clk),
      .rst_n (rst_n),
      .start (sweep_start),
      .step  (sweep_step),
      .next_x(sw_next_x),
      .next_y(sw_next_y),
      .done  (sweep_done)
   );

   // Memory-side and result registers; strobes default low and are re-armed per state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_read_addr    <= '0;
         mem_write_addr   <= '0;
         wdata_q          <= EMPTY;
         mem_write_enable <= 1'b0;
         result_valid     <= 1'b0;
         result_q         <= RES_MISS;
      end else begin
         result_valid     <= 1'b0;
         mem_write_enable <= 1'b0;
         case (state_q)
            IDLE: begin
               if (clear_req) begin
                  mem_write_addr   <= '0;
                  wdata_q          <= EMPTY;
                  mem_write_enable <= 1'b1;
               end else if (shot_valid) begin
                  mem_read_addr <= {shot_x, shot_y};
               end
            end
            EVAL: begin
               result_q         <= eval_res;
               result_valid     <= 1'b1;
               mem_write_enable <= eval_we;
               mem_write_addr   <= mem_read_addr;
               wdata_q          <= eval_data;
            end
            CLEAR: begin
               if (!sweep_done) begin
                  mem_write_addr   <= {sw_next_x, sw_next_y};
                  wdata_q          <= EMPTY;
                  mem_write_enable <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign result         = result_q;
   assign mem_write_data = wdata_q;

   // Decrement is applied on the RESP edge so all_sunk, computed from the next
   // counter value, rises in the cycle right after RESP.
   always_comb begin
      cnt_nxt   = cnt_q;
      armed_nxt = armed_q;
      if (state_q == CLEAR) begin
         cnt_nxt   = '0;
         armed_nxt = 1'b0;
      end else if (ships_load) begin
         cnt_nxt   = ships_count;
         armed_nxt = 1'b1;
      end else if ((state_q == RESP) && (result_q == RES_HIT) && (cnt_q != '0)) begin
         cnt_nxt = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         armed_q  <= 1'b0;
         all_sunk <= 1'b0;
      end else begin
         cnt_q    <= cnt_nxt;
         armed_q  <= armed_nxt;
         all_sunk <= armed_nxt && (cnt_nxt == '0);
      end
   end

endmodule
